ts_chan_reader: RTL and testbench

TS_CHAN_READER -- requirements
Module: ts_chan_reader

---
 rtl/ts_chan_reader_pkg.sv | 20 ++
 rtl/sdp_ram_d64_w32.sv | 29 ++
 rtl/ts_chan_reader.sv | 212 +++++++++++++++++++++
 tb/tb_ts_chan_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_chan_reader_pkg.sv
// ts_chan_reader_pkg
// Shared constants and types for the transport-stream channel reader:
//   state_t           - reader FSM state encodings
//   P_TS_BUFFER_SIZE  - packet size in bytes
//   WORDS_PER_PKT     - 32-bit payload words per packet
//   SYNC_BYTE         - expected value of the first byte after the header
package ts_chan_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam int         P_TS_BUFFER_SIZE = 192;
  localparam int         WORDS_PER_PKT    = 48;
  localparam logic [7:0] SYNC_BYTE        = 8'h47;

endpackage

// File: rtl/sdp_ram_d64_w32.sv
// sdp_ram_d64_w32
// Simple dual-port RAM, 64 words x 32 bits, single clock, registered read
// (data for raddr appears one cycle after it is presented).
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, 1-cycle latency
module sdp_ram_d64_w32 (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [5:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [0:63];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ts_chan_reader.sv
// ts_chan_reader
// Requests one transport-stream packet from an upstream payload FIFO,
// captures its 48 words into a local RAM, checks the length, then replays
// it as a 192-byte stream, MSB byte of each word first, under ready/valid
// flow control.
// Ports:
//   payload_clk, payload_rst           - clock, synchronous active-high reset
//   payload_req_in                     - upstream holds at least one packet
//   payload_in_valid/start/end/data    - upstream packet words
//   chan_out_req                       - packet request to upstream
//   chan_out_ack                       - packet-done pulse from upstream (monitored only)
//   ts_out_valid/start/end/data, ts_out_ready - downstream byte stream
//   length_err, timeout_err, sync_err  - single-cycle error pulses
//   pkt_count                          - packets forwarded (wrapping)
module ts_chan_reader #(
  parameter int PAYLOAD_DATA_WIDTH = 32,
  parameter int P_TS_BUFFER_SIZE   = 192,
  parameter int P_REQ_TIMEOUT      = 255
) (
  input  logic                          payload_clk,
  input  logic                          payload_rst,
  input  logic                          payload_req_in,
  input  logic                          payload_in_valid,
  input  logic                          payload_in_start,
  input  logic                          payload_in_end,
  input  logic [PAYLOAD_DATA_WIDTH-1:0] payload_in_data,
  output logic                          chan_out_req,
  input  logic                          chan_out_ack,
  output logic                          ts_out_valid,
  output logic                          ts_out_start,
  output logic                          ts_out_end,
  output logic [7:0]                    ts_out_data,
  input  logic                          ts_out_ready,
  output logic                          length_err,
  output logic                          timeout_err,
  output logic                          sync_err,
  output logic [15:0]                   pkt_count
);

  import ts_chan_reader_pkg::*;

  localparam int         TMO_W     = $clog2(P_REQ_TIMEOUT + 1);
  localparam logic [5:0] WORDS     = 6'(WORDS_PER_PKT);
  localparam logic [7:0] LAST_BYTE = 8'(P_TS_BUFFER_SIZE - 1);

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c < WORDS) ? c + 6'd1 : c;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  state_t            state, state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [5:0]        wr_cnt, wr_cnt_nxt;
  logic              ram_we;
  logic [5:0]        ram_waddr;
  logic [5:0]        ram_raddr;
  logic [31:0]       ram_rdata;
  logic              len_err_nxt, tmo_err_nxt;

  logic [7:0]        byte_idx;
  logic              vld_p0;
  logic [31:0]       word_p1;
  logic              vld_p1;
  logic              xfer, out_free, load_byte, issue_rd;

  // The upstream done pulse never gates progress; it is observed only.
  logic              unused_ack;
  assign unused_ack = chan_out_ack;

  assign chan_out_req = (state == S_REQ) || (state == S_RECV);
  assign xfer         = ts_out_valid && ts_out_ready;
  assign out_free     = !ts_out_valid || ts_out_ready;
  assign load_byte    = (state == S_SEND) && vld_p1 && out_free;
  assign issue_rd     = (state == S_SEND) && !vld_p1 && !vld_p0 && (byte_idx <= LAST_BYTE);
  assign ram_raddr    = byte_idx[7:2];

  sdp_ram_d64_w32 u_ram (
    .clk   (payload_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (payload_in_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt   = state;
    wr_cnt_nxt  = wr_cnt;
    ram_we      = 1'b0;
    ram_waddr   = wr_cnt;
    len_err_nxt = 1'b0;
    tmo_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (payload_req_in) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (payload_in_valid && payload_in_start) begin
          ram_we     = 1'b1;
          ram_waddr  = 6'd0;
          wr_cnt_nxt = 6'd1;
          state_nxt  = S_RECV;
        end else if (tmo_cnt == TMO_W'(P_REQ_TIMEOUT - 1)) begin
          tmo_err_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_RECV: begin
        if (payload_in_valid) begin
          if (payload_in_start) begin
            // A new start mid-packet means the old one was short: resync.
            len_err_nxt = 1'b1;
            ram_we      = 1'b1;
            ram_waddr   = 6'd0;
            wr_cnt_nxt  = 6'd1;
          end else begin
            ram_we     = (wr_cnt < WORDS);
            wr_cnt_nxt = sat_inc(wr_cnt);
          end
          if (payload_in_end) begin
            if (wr_cnt_nxt == WORDS) begin
              state_nxt = S_SEND;
            end else begin
              len_err_nxt = 1'b1;
              state_nxt   = S_IDLE;
            end
          end
        end
      end
      S_SEND: begin
        if (xfer && ts_out_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      wr_cnt      <= '0;
      length_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= (state == S_REQ) ? tmo_cnt + 1'b1 : '0;
      wr_cnt      <= wr_cnt_nxt;
      length_err  <= len_err_nxt;
      timeout_err <= tmo_err_nxt;
    end
  end

  // p0: RAM read issued, p1: word captured, then byte output register
  always_ff @(posedge payload_clk) begin
    if (vld_p0) begin
      word_p1 <= ram_rdata;
    end
  end

  always_ff @(posedge payload_clk) begin
    if (payload_rst) begin
      byte_idx     <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      ts_out_valid <= 1'b0;
      ts_out_start <= 1'b0;
      ts_out_end   <= 1'b0;
      ts_out_data  <= '0;
      sync_err     <= 1'b0;
      pkt_count    <= '0;
    end else begin
      if (state != S_SEND) begin
        byte_idx <= '0;
        vld_p0   <= 1'b0;
        vld_p1   <= 1'b0;
      end else begin
        vld_p0 <= issue_rd;
        if (vld_p0) begin
          vld_p1 <= 1'b1;
        end else if (load_byte && (byte_idx[1:0] == 2'd3)) begin
          vld_p1 <= 1'b0;
        end
        if (load_byte) byte_idx <= byte_idx + 8'd1;
      end

      if (load_byte) begin
        ts_out_valid <= 1'b1;
        ts_out_data  <= pick_byte(word_p1, byte_idx[1:0]);
        ts_out_start <= (byte_idx == 8'd0);
        ts_out_end   <= (byte_idx == LAST_BYTE);
      end else if (xfer) begin
        ts_out_valid <= 1'b0;
        ts_out_start <= 1'b0;
        ts_out_end   <= 1'b0;
      end

      // byte_idx runs one ahead of the presented byte, so 5 means byte 4.
      sync_err <= xfer && (byte_idx == 8'd5) && (ts_out_data != SYNC_BYTE);

      if (xfer && ts_out_end) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_chan_reader.sv
// tb_ts_chan_reader
// Directed bench for ts_chan_reader: a table of packet scenarios driven and
// scored in a loop, plus hand-written timeout and reset-mid-send sequences.
module tb_ts_chan_reader;

  logic        payload_clk = 1'b0;
  logic        payload_rst;
  logic        payload_req_in;
  logic        payload_in_valid;
  logic        payload_in_start;
  logic        payload_in_end;
  logic [31:0] payload_in_data;
  logic        chan_out_req;
  logic        chan_out_ack;
  logic        ts_out_valid;
  logic        ts_out_start;
  logic        ts_out_end;
  logic [7:0]  ts_out_data;
  logic        ts_out_ready;
  logic        length_err;
  logic        timeout_err;
  logic        sync_err;
  logic [15:0] pkt_count;

  ts_chan_reader dut (
    .payload_clk      (payload_clk),
    .payload_rst      (payload_rst),
    .payload_req_in   (payload_req_in),
    .payload_in_valid (payload_in_valid),
    .payload_in_start (payload_in_start),
    .payload_in_end   (payload_in_end),
    .payload_in_data  (payload_in_data),
    .chan_out_req     (chan_out_req),
    .chan_out_ack     (chan_out_ack),
    .ts_out_valid     (ts_out_valid),
    .ts_out_start     (ts_out_start),
    .ts_out_end       (ts_out_end),
    .ts_out_data      (ts_out_data),
    .ts_out_ready     (ts_out_ready),
    .length_err       (length_err),
    .timeout_err      (timeout_err),
    .sync_err         (sync_err),
    .pkt_count        (pkt_count)
  );

  always #5 payload_clk = ~payload_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] cap_mem [0:4095];
  int         cap_n       = 0;
  int         flag_errs   = 0;
  int         stall_errs  = 0;
  int         len_pulses  = 0;
  int         tmo_pulses  = 0;
  int         sync_pulses = 0;
  int         sync_pos    = -1;
  int         valid_cyc   = 0;
  logic       prev_stall  = 1'b0;
  logic [9:0] prev_out    = '0;
  int         mon_idx;

  // Written only by the main process
  int cap_base = 0;
  bit rdy_mode = 1'b0;

  initial begin
    forever begin
      @(negedge payload_clk);
      if (length_err)  len_pulses++;
      if (timeout_err) tmo_pulses++;
      if (sync_err) begin
        sync_pulses++;
        sync_pos = cap_n - cap_base;
      end
      if (ts_out_valid) valid_cyc++;
      if (prev_stall && !payload_rst) begin
        if (!ts_out_valid || ({ts_out_start, ts_out_end, ts_out_data} != prev_out)) stall_errs++;
      end
      prev_stall = ts_out_valid && !ts_out_ready;
      prev_out   = {ts_out_start, ts_out_end, ts_out_data};
      if (ts_out_valid && ts_out_ready) begin
        mon_idx = cap_n - cap_base;
        if ((ts_out_start != (mon_idx == 0)) || (ts_out_end != (mon_idx == 191))) flag_errs++;
        cap_mem[cap_n[11:0]] = ts_out_data;
        cap_n++;
      end
    end
  end

  initial begin
    ts_out_ready = 1'b1;
    forever begin
      @(posedge payload_clk);
      #1;
      ts_out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge payload_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_chan_out_req"}, int'(chan_out_req), 0);
    check({tag, "_ts_out_valid"}, int'(ts_out_valid), 0);
    check({tag, "_ts_out_start"}, int'(ts_out_start), 0);
    check({tag, "_ts_out_end"},   int'(ts_out_end), 0);
    check({tag, "_ts_out_data"},  int'(ts_out_data), 0);
    check({tag, "_length_err"},   int'(length_err), 0);
    check({tag, "_timeout_err"},  int'(timeout_err), 0);
    check({tag, "_sync_err"},     int'(sync_err), 0);
    check({tag, "_pkt_count"},    int'(pkt_count), 0);
  endtask

  function automatic logic [31:0] pkt_word(input int i, input bit bad);
    if (bad && i == 1) return 32'h12345678;
    return 32'h47000000 + 32'(i);
  endfunction

  task automatic drive_pkt(input int nw, input bit bad, input bit junk, input string tag);
    int guard;
    guard = 0;
    payload_req_in = 1'b1;
    while (!chan_out_req && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_req_seen"}, int'(chan_out_req), 1);
    payload_req_in = 1'b0;
    if (junk) begin
      payload_in_valid = 1'b1;
      payload_in_start = 1'b0;
      payload_in_end   = 1'b0;
      payload_in_data  = 32'hDEADBEEF;
      tick();
    end
    for (int i = 0; i < nw; i++) begin
      payload_in_valid = 1'b1;
      payload_in_start = (i == 0);
      payload_in_end   = (i == nw - 1);
      payload_in_data  = pkt_word(i, bad);
      tick();
    end
    payload_in_valid = 1'b0;
    payload_in_start = 1'b0;
    payload_in_end   = 1'b0;
    chan_out_ack     = 1'b1;
    check({tag, "_req_drop"}, int'(chan_out_req), 0);
    tick();
    chan_out_ack = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int g;
    g = 0;
    while ((cap_n - cap_base) < n && g < limit) begin
      tick();
      g++;
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input bit bad);
    int         nbad;
    logic [11:0] ai;
    logic [31:0] w;
    logic [7:0]  eb;
    nbad = 0;
    for (int k = 0; k < n && k < (cap_n - cap_base); k++) begin
      ai = 12'(cap_base + k);
      w  = pkt_word(k / 4, bad);
      eb = 8'(w >> (8 * (3 - (k % 4))));
      if (cap_mem[ai] != eb) nbad++;
    end
    check({tag, "_byte_errs"}, nbad, 0);
  endtask

  typedef struct {
    int nw;
    bit bad;
    bit junk;
    bit bp;
    int exp_bytes;
    int exp_len;
    int exp_sync;
    int exp_pkt_inc;
  } vec_t;

  vec_t vecs[6];
  int   exp_pkt = 0;

  initial begin
    int len_b, tmo_b, sync_b, flag_b, stall_b, valid_b, n;
    string tag;

    vecs[0] = '{48, 1'b0, 1'b1, 1'b0, 192, 0, 0, 1};
    vecs[1] = '{48, 1'b0, 1'b0, 1'b1, 192, 0, 0, 1};
    vecs[2] = '{40, 1'b0, 1'b0, 1'b0,   0, 1, 0, 0};
    vecs[3] = '{48, 1'b1, 1'b0, 1'b0, 192, 0, 1, 1};
    vecs[4] = '{48, 1'b1, 1'b0, 1'b1, 192, 0, 1, 1};
    vecs[5] = '{47, 1'b0, 1'b0, 1'b1,   0, 1, 0, 0};

    payload_rst      = 1'b1;
    payload_req_in   = 1'b0;
    payload_in_valid = 1'b0;
    payload_in_start = 1'b0;
    payload_in_end   = 1'b0;
    payload_in_data  = '0;
    chan_out_ack     = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    payload_rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      tag      = $sformatf("v%0d", v);
      cap_base = cap_n;
      len_b    = len_pulses;
      tmo_b    = tmo_pulses;
      sync_b   = sync_pulses;
      flag_b   = flag_errs;
      stall_b  = stall_errs;
      valid_b  = valid_cyc;
      rdy_mode = vecs[v].bp;
      drive_pkt(vecs[v].nw, vecs[v].bad, vecs[v].junk, tag);
      if (vecs[v].exp_bytes > 0) wait_bytes(vecs[v].exp_bytes, 3000);
      else repeat (30) tick();
      repeat (5) tick();
      rdy_mode = 1'b0;
      exp_pkt += vecs[v].exp_pkt_inc;
      check({tag, "_byte_count"}, cap_n - cap_base, vecs[v].exp_bytes);
      check_bytes(tag, vecs[v].exp_bytes, vecs[v].bad);
      check({tag, "_flag_errs"},   flag_errs - flag_b, 0);
      check({tag, "_stall_errs"},  stall_errs - stall_b, 0);
      check({tag, "_length_err"},  len_pulses - len_b, vecs[v].exp_len);
      check({tag, "_sync_err"},    sync_pulses - sync_b, vecs[v].exp_sync);
      check({tag, "_timeout_err"}, tmo_pulses - tmo_b, 0);
      check({tag, "_pkt_count"},   int'(pkt_count), exp_pkt);
      check({tag, "_idle_req"},    int'(chan_out_req), 0);
      check({tag, "_idle_valid"},  int'(ts_out_valid), 0);
      if (vecs[v].exp_sync != 0) check({tag, "_sync_pos"}, sync_pos, 5);
      if (vecs[v].exp_bytes == 0) check({tag, "_valid_cycles"}, valid_cyc - valid_b, 0);
    end

    // Timeout: request raised, no start ever arrives
    tmo_b = tmo_pulses;
    len_b = len_pulses;
    payload_req_in = 1'b1;
    n = 0;
    while (!chan_out_req && n < 20) begin
      tick();
      n++;
    end
    check("tmo_req_seen", int'(chan_out_req), 1);
    payload_req_in = 1'b0;
    n = 0;
    while (chan_out_req && n < 400) begin
      n++;
      tick();
    end
    check_range("tmo_req_cycles", n, 255, 256);
    tick();
    check("tmo_pulses", tmo_pulses - tmo_b, 1);
    check("tmo_len_pulses", len_pulses - len_b, 0);
    check("tmo_req_low", int'(chan_out_req), 0);
    check("tmo_pkt_count", int'(pkt_count), exp_pkt);

    // Reset mid-send after 100 bytes, then a fresh packet
    cap_base = cap_n;
    drive_pkt(48, 1'b0, 1'b0, "rst_a");
    wait_bytes(100, 1000);
    check("rst_pre_bytes", cap_n - cap_base, 100);
    payload_rst = 1'b1;
    tick();
    check_zero_outputs("rst_mid");
    payload_rst = 1'b0;
    exp_pkt = 0;
    tick();
    cap_base = cap_n;
    flag_b   = flag_errs;
    drive_pkt(48, 1'b0, 1'b0, "rst_b");
    wait_bytes(192, 1000);
    repeat (5) tick();
    check("rst_b_byte_count", cap_n - cap_base, 192);
    check_bytes("rst_b", 192, 1'b0);
    check("rst_b_flag_errs", flag_errs - flag_b, 0);
    check("rst_b_pkt_count", int'(pkt_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
